// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg : state encodings, op classes and instruction field positions
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t FETCH  = 2'd0;
  localparam state_t DECODE = 2'd1;
  localparam state_t EXEC   = 2'd2;
  localparam state_t HALT   = 2'd3;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_JMP = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  localparam int MEM_BIT  = 7;
  localparam int CLASS_HI = 6;
  localparam int CLASS_LO = 5;
  localparam int RW_BIT   = 4;
  localparam int ARG_HI   = 3;
  localparam int ARG_LO   = 0;
  localparam int ARG_W    = ARG_HI - ARG_LO + 1;

  // Local (non-RAM) op test: class bits only mean something when the mem bit is clear.
  function automatic logic is_local_op(input logic mem, input logic [1:0] cls,
                                       input logic [1:0] op);
    return !mem && (cls == op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode : splits the instruction register into op flags and argument
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_decode
  import fetch_ctrl_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic [IW-1:0]    ir,
  output logic             is_mem,
  output logic             is_jmp,
  output logic             is_ldi,
  output logic             is_hlt,
  output logic [ARG_W-1:0] arg,
  output logic [IW-1:0]    mem_instr
);

  logic [1:0] cls;

  assign cls       = ir[CLASS_HI:CLASS_LO];
  assign is_mem    = ir[MEM_BIT];
  assign is_jmp    = is_local_op(ir[MEM_BIT], cls, OP_JMP);
  assign is_ldi    = is_local_op(ir[MEM_BIT], cls, OP_LDI);
  assign is_hlt    = is_local_op(ir[MEM_BIT], cls, OP_HLT);
  assign arg       = ir[ARG_HI:ARG_LO];
  // Word handed to the RAM; all-zero for local ops so the RAM ignores it.
  assign mem_instr = ir[MEM_BIT] ? ir : '0;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : FETCH/DECODE/EXEC sequencer feeding the data RAM.
// Optional SINGLE_STEP_EN adds a step input and a post-EXEC WAIT state.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int IW   = 8,
  parameter int DW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  output logic [IW-1:0]   instr,
  inout  wire  [DW-1:0]   bus,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      state,
  output logic            halted
);

  logic [IW-1:0]    ir;
  logic             bus_en;
  logic [DW-1:0]    bus_q;
  logic             is_mem;
  logic             is_jmp;
  logic             is_ldi;
  logic             is_hlt;
  logic [ARG_W-1:0] arg;
  logic [IW-1:0]    mem_instr;

  fetch_decode #(.IW(IW)) u_decode (
    .ir        (ir),
    .is_mem    (is_mem),
    .is_jmp    (is_jmp),
    .is_ldi    (is_ldi),
    .is_hlt    (is_hlt),
    .arg       (arg),
    .mem_instr (mem_instr)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic wait_q;
  logic step_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  assign step_rise = step & ~step_q;
  // WAIT shares the HALT encoding; wait_q tells the two apart.
  assign halted    = (state == HALT) && !wait_q;
`else
  assign halted    = (state == HALT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      instr  <= '0;
      bus_en <= 1'b0;
      bus_q  <= '0;
`ifdef SINGLE_STEP_EN
      wait_q <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ir    <= rom_data;
            pc    <= pc + 1'b1;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_hlt) begin
            state <= HALT;
          end else begin
            // EXEC outputs are registered here so they are clean for the whole EXEC cycle.
            state  <= EXEC;
            instr  <= mem_instr;
            bus_en <= is_ldi;
            bus_q  <= DW'(arg);
          end
        end
        EXEC: begin
          instr  <= '0;
          bus_en <= 1'b0;
          if (is_jmp) pc <= PC_W'(arg);
`ifdef SINGLE_STEP_EN
          state  <= HALT;
          wait_q <= 1'b1;
`else
          state  <= FETCH;
`endif
        end
        HALT: begin
`ifdef SINGLE_STEP_EN
          if (wait_q && step_rise) begin
            state  <= FETCH;
            wait_q <= 1'b0;
          end
`endif
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign rom_addr = pc;
  assign bus      = bus_en ? bus_q : {DW{1'bz}};

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch/sequencing stage directly upstream of the 4-bit data RAM.
- Reads 8-bit instruction words from an external asynchronous program ROM using a 4-bit PC and latches them into an instruction register.
- Runs a FETCH/DECODE/EXEC cycle and presents the instruction to the RAM on `instr` for exactly one EXEC cycle.
- Handles non-memory ops locally: NOP, JMP, LDI (drives an immediate onto the shared bus) and HLT.

Parameters:
- PC_W, 4, program counter width; ROM depth is 2^PC_W.
- IW, 8, instruction width.
- DW, 4, data bus width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  fetch enable; while 0, sequencer holds in FETCH.
- rom_addr  output  PC_W  program ROM address, always equal to pc.
- rom_data  input  IW  program ROM word; combinational with respect to rom_addr.
- instr  output  IW  instruction to the RAM; non-zero only during EXEC of a memory op.
- bus  inout  DW  shared tri-state data bus; driven only during EXEC of LDI, otherwise Z.
- pc  output  PC_W  current program counter.
- state  output  2  FSM state, for debug.
- halted  output  1  high in HALT.

Behaviour:
- Reset (async, rst=1), all values apply immediately:
  - pc=0, ir=0, instr=8'h00, bus=Z, state=FETCH, halted=0.
- Instruction format:
  - [7] memory op (1 = RAM access).
  - [6:5] op class, used only when [7]=0: 00 NOP, 01 JMP, 10 LDI, 11 HLT.
  - [4] RAM write=1/read=0.
  - [3:0] address or immediate.
- States: FETCH=0, DECODE=1, EXEC=2, HALT=3.
- FETCH:
  - If run=1: ir<=rom_data at the clock edge, pc<=pc+1 (wraps 15->0), go to DECODE.
  - If run=0: hold, pc unchanged.
- DECODE:
  - One cycle, no outputs asserted.
  - Go to HALT if ir[7]=0 and ir[6:5]=11, otherwise go to EXEC.
- EXEC: one cycle, then FETCH.
  - Memory op: instr=ir (registered; valid for the full EXEC cycle), so the RAM samples it at the closing edge.
  - LDI: bus=ir[3:0]; instr=0.
  - JMP: pc<=ir[3:0] at the closing edge; this overrides the increment done in FETCH.
  - NOP: nothing.
- instr is 8'h00 in every state other than EXEC. bit7=0 means the RAM ignores it.
- Throughput: 3 cycles per instruction. Latency from ROM word to RAM instr is 2 edges.
- HALT:
  - halted=1, pc frozen, instr=0, bus=Z.
  - Leaves HALT only on rst; run is ignored.
- run dropping mid-instruction: the instruction in flight completes, then the sequencer holds in FETCH.
- JMP to the current pc: legal, loops forever (not a halt).
- pc=15 fetch: pc wraps to 0.
- rst asserted during EXEC: instr and bus release in the same cycle, asynchronously.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Extra input step (1 bit).
  - After EXEC, the FSM enters a WAIT state (encoding reuses 2'b11 with halted=0, distinguished by an internal bit). state output reports 3.
  - WAIT advances to FETCH only on a rising edge of step, detected with a registered previous value that resets to 0.
- When undefined: no step port; EXEC goes straight to FETCH.

Decomposition:
- Shared package holds:
  - State encodings: FETCH, DECODE, EXEC, HALT.
  - Op-class constants: OP_NOP=2'b00, OP_JMP=2'b01, OP_LDI=2'b10, OP_HLT=2'b11.
  - Instruction field bit positions: MEM_BIT=7, CLASS_HI=6, CLASS_LO=5, RW_BIT=4, ARG_HI=3, ARG_LO=0.
  - These constants are shared with the RAM and any future ALU decode.
- One natural sub-module: fetch_decode. It takes ir and produces is_mem, is_jmp, is_ldi, is_hlt and arg.
- The FSM, PC and IR stay in the top.

Test Plan:
1. Reset, then ROM[0]=8'b1_00_1_0001, run=1 -> instr=8'h91 only in cycle 3 (EXEC); pc=1; instr=0 in cycles 1-2.
2. ROM[0]=8'b0_10_0_1010 (LDI 10) -> bus=4'b1010 during EXEC only, Z otherwise; instr stays 0.
3. ROM[0]=8'b0_01_0_0101 (JMP 5), ROM[5]=8'b1_00_0_0011 -> next fetch has rom_addr=5; the following EXEC has instr=8'h83.
4. ROM[15]=NOP with pc preset by JMP 15 -> after the fetch pc=0 (wrap).
5. ROM[2]=8'b0_11_0_0000 (HLT) -> state=3, halted=1, pc=3 frozen for 10 cycles despite run=1; rst releases to pc=0.
6. run=0 after FETCH of a memory op -> EXEC still issues instr, then holds in FETCH with pc unchanged; with SINGLE_STEP_EN, WAIT holds until a step pulse.
